slot_alloc: RTL and testbench



---
 rtl/slot_alloc.sv | 116 +++++++++++
 tb/tb_slot_alloc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_alloc.sv
// Round-robin slot allocator: owns a W-entry occupancy vector, offers the
// first free slot at or after a rotating pointer, and takes back released
// slots. The offer is a pure function of registered state.
module slot_alloc #(
  parameter int W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  input  logic                 i_alloc_req,
  output logic                 o_alloc_vld,
  output logic [$clog2(W)-1:0] o_alloc_idx,
  input  logic                 i_free_vld,
  input  logic [$clog2(W)-1:0] i_free_idx,
  output logic [W-1:0]         o_busy,
  output logic [$clog2(W):0]   o_cnt,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_err_dfree
);

  localparam int IW = $clog2(W);
  localparam int CW = IW + 1;

  // W expressed at counter width, so it also serves as the index range bound.
  localparam logic [CW-1:0] W_CNT  = CW'(W);
  localparam logic [IW-1:0] W_LAST = IW'(W - 1);

  logic [W-1:0]  busy_q, busy_d;
  logic [IW-1:0] ptr_q,  ptr_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic          err_q,  err_d;

  logic [IW-1:0] offer_idx;
  logic          offer_found;
  logic [CW-1:0] cand;
  logic          full;
  logic          fire;
  logic          free_in_range;
  logic          free_ok;

  assign full = (cnt_q == W_CNT);

  // Circular first-free search starting at ptr_q.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    offer_idx   = '0;
    offer_found = 1'b0;
    cand        = '0;
    for (int k = 0; k < W; k++) begin
      // ptr_q < W, so ptr_q + k < 2W and one conditional subtract wraps it.
      cand = {1'b0, ptr_q} + CW'(k);
      if (cand >= W_CNT) begin
        cand = cand - W_CNT;
      end
      if (!offer_found && !busy_q[cand[IW-1:0]]) begin
        offer_found = 1'b1;
        offer_idx   = cand[IW-1:0];
      end
    end
  end

  assign fire          = i_alloc_req & ~full;
  assign free_in_range = ({1'b0, i_free_idx} < W_CNT);
  assign free_ok       = i_free_vld & free_in_range & busy_q[i_free_idx];

  // Next-state: apply the allocation and the release independently; they
  // never touch the same slot because the offered slot is always free.
  always_comb begin
    busy_d = busy_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    err_d  = i_free_vld & ~free_ok;

    if (fire) begin
      busy_d[offer_idx] = 1'b1;
      // Explicit wrap so non-power-of-two W returns to slot 0.
      ptr_d = (offer_idx == W_LAST) ? '0 : offer_idx + IW'(1);
    end
    if (free_ok) begin
      busy_d[i_free_idx] = 1'b0;
    end

    unique case ({fire, free_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      busy_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      busy_q <= busy_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign o_alloc_vld = ~full;
  assign o_alloc_idx = offer_idx;
  assign o_busy      = busy_q;
  assign o_cnt       = cnt_q;
  assign o_full      = full;
  assign o_empty     = (cnt_q == '0);
  assign o_err_dfree = err_q;

endmodule

// File: tb/tb_slot_alloc.sv
// Self-checking bench for slot_alloc: directed scenarios plus random traffic,
// all checked against an array-based reference of the allocation rules.
module tb_slot_alloc;

  localparam int W  = 16;
  localparam int W2 = 12;

  logic        clk;
  logic        arst_n;
  logic        alloc_req;
  logic        alloc_vld;
  logic [3:0]  alloc_idx;
  logic        free_vld;
  logic [3:0]  free_idx;
  logic [15:0] busy;
  logic [4:0]  cnt;
  logic        full;
  logic        empty;
  logic        err;

  logic        req12;
  logic        vld12;
  logic [3:0]  idx12;
  logic        fvld12;
  logic [3:0]  fidx12;
  logic [11:0] busy12;
  logic [4:0]  cnt12;
  logic        full12;
  logic        empty12;
  logic        err12;

  int checks = 0;
  int errors = 0;

  // Reference state: occupancy as a bit array, rotating start, error pulse.
  bit mbusy[W];
  int mptr;
  bit merr;

  slot_alloc #(.W(W)) dut (
    .i_clk(clk), .i_arst_n(arst_n),
    .i_alloc_req(alloc_req), .o_alloc_vld(alloc_vld), .o_alloc_idx(alloc_idx),
    .i_free_vld(free_vld), .i_free_idx(free_idx),
    .o_busy(busy), .o_cnt(cnt), .o_full(full), .o_empty(empty),
    .o_err_dfree(err)
  );

  slot_alloc #(.W(W2)) dut12 (
    .i_clk(clk), .i_arst_n(arst_n),
    .i_alloc_req(req12), .o_alloc_vld(vld12), .o_alloc_idx(idx12),
    .i_free_vld(fvld12), .i_free_idx(fidx12),
    .o_busy(busy12), .o_cnt(cnt12), .o_full(full12), .o_empty(empty12),
    .o_err_dfree(err12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < W; i++) n += mbusy[i];
    return n;
  endfunction

  function automatic int m_offer();
    for (int k = 0; k < W; k++) begin
      if (!mbusy[(mptr + k) % W]) return (mptr + k) % W;
    end
    return 0;
  endfunction

  function automatic logic [15:0] m_vec();
    logic [15:0] v;
    for (int i = 0; i < W; i++) v[i] = mbusy[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < W; i++) mbusy[i] = 1'b0;
    mptr = 0;
    merr = 1'b0;
  endtask

  task automatic m_update(input bit req, input bit fv, input int fi);
    bit can_alloc;
    int o;
    bit ok;
    can_alloc = (m_cnt() < W);
    o  = m_offer();
    ok = fv && (fi < W) && mbusy[fi];
    if (req && can_alloc) begin
      mbusy[o] = 1'b1;
      mptr = (o + 1) % W;
    end
    if (ok) mbusy[fi] = 1'b0;
    merr = fv && !ok;
  endtask

  task automatic compare_all(input string tag);
    int n;
    n = m_cnt();
    check({tag, ".vld"},   32'(alloc_vld), 32'(n < W));
    check({tag, ".idx"},   32'(alloc_idx), 32'(m_offer()));
    check({tag, ".busy"},  32'(busy),      32'(m_vec()));
    check({tag, ".cnt"},   32'(cnt),       32'(n));
    check({tag, ".full"},  32'(full),      32'(n == W));
    check({tag, ".empty"}, 32'(empty),     32'(n == 0));
    check({tag, ".err"},   32'(err),       32'(merr));
  endtask

  // One clock of stimulus: check current outputs, clock, advance the model.
  task automatic step(input string tag, input bit req, input bit fv, input int fi);
    logic [31:0] fi_v;
    fi_v      = 32'(fi);
    alloc_req = req;
    free_vld  = fv;
    free_idx  = fi_v[3:0];
    compare_all(tag);
    @(posedge clk);
    m_update(req, fv, fi);
    #1;
    alloc_req = 1'b0;
    free_vld  = 1'b0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #2;
    m_reset();
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n = 1'b0;
    alloc_req = 1'b0; free_vld = 1'b0; free_idx = '0;
    req12 = 1'b0; fvld12 = 1'b0; fidx12 = '0;
    m_reset();
    #12;
    compare_all("reset");
    check("reset.vld12", 32'(vld12), 32'd1);
    check("reset.empty12", 32'(empty12), 32'd1);
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill: offers 0..15 in order; the W=12 instance fills 0..11 alongside.
    req12 = 1'b1;
    for (int i = 0; i < W; i++) begin
      check("fill.seq", 32'(alloc_idx), 32'(i));
      if (i < W2) check("fill12.seq", 32'(idx12), 32'(i));
      step("fill", 1'b1, 1'b0, 0);
    end
    req12 = 1'b0;
    compare_all("full");
    check("full.busy", 32'(busy), 32'h0000FFFF);
    check("full.cnt", 32'(cnt), 32'd16);
    check("full12.busy", 32'(busy12), 32'h00000FFF);
    check("full12.cnt", 32'(cnt12), 32'd12);
    check("full12.vld", 32'(vld12), 32'd0);

    // Free 5 while full and requesting: no grant that cycle, 5 offered next.
    step("free_full", 1'b1, 1'b1, 5);
    check("refill.vld", 32'(alloc_vld), 32'd1);
    check("refill.idx", 32'(alloc_idx), 32'd5);
    step("refill", 1'b1, 1'b0, 0);
    check("refill.full", 32'(full), 32'd1);
    // Pointer now 6: with slots 2 and 9 free, 9 must be offered.
    step("free2", 1'b0, 1'b1, 2);
    step("free9", 1'b0, 1'b1, 9);
    check("ptr6.idx", 32'(alloc_idx), 32'd9);

    // Simultaneous alloc and free from busy=00FF, ptr=8.
    do_reset();
    for (int i = 0; i < 8; i++) step("fill8", 1'b1, 1'b0, 0);
    check("sim.pre_busy", 32'(busy), 32'h000000FF);
    step("sim", 1'b1, 1'b1, 3);
    check("sim.busy", 32'(busy), 32'h000001F7);
    check("sim.cnt", 32'(cnt), 32'd8);
    check("sim.next", 32'(alloc_idx), 32'd9);

    // Wrap from ptr=15 and a search that wraps from ptr=1 back to 0.
    do_reset();
    for (int i = 0; i < 15; i++) step("fill15", 1'b1, 1'b0, 0);
    step("free0", 1'b0, 1'b1, 0);
    check("wrap.busy", 32'(busy), 32'h00007FFE);
    check("wrap.idx15", 32'(alloc_idx), 32'd15);
    step("wrap.fire", 1'b1, 1'b0, 0);
    check("wrap.idx0", 32'(alloc_idx), 32'd0);
    step("wrap.fill0", 1'b1, 1'b0, 0);
    step("wrap.free0", 1'b0, 1'b1, 0);
    check("wrap2.busy", 32'(busy), 32'h0000FFFE);
    check("wrap2.idx", 32'(alloc_idx), 32'd0);

    // Double free and out-of-range free on the W=12 instance.
    do_reset();
    for (int i = 0; i < 3; i++) step("fill3", 1'b1, 1'b0, 0);
    fvld12 = 1'b1; fidx12 = 4'd13;
    step("dfree", 1'b0, 1'b1, 7);
    fvld12 = 1'b0;
    check("dfree.err", 32'(err), 32'd1);
    check("dfree.busy", 32'(busy), 32'h00000007);
    check("dfree.cnt", 32'(cnt), 32'd3);
    check("oor12.err", 32'(err12), 32'd1);
    check("oor12.busy", 32'(busy12), 32'd0);
    check("oor12.cnt", 32'(cnt12), 32'd0);
    step("dfree.after", 1'b0, 1'b0, 0);
    check("dfree.pulse", 32'(err), 32'd0);
    check("oor12.pulse", 32'(err12), 32'd0);

    // Asynchronous reset between clock edges.
    do_reset();
    for (int i = 0; i < 5; i++) step("fill5", 1'b1, 1'b0, 0);
    #3;
    arst_n = 1'b0;
    #1;
    check("areset.busy", 32'(busy), 32'd0);
    check("areset.cnt", 32'(cnt), 32'd0);
    check("areset.empty", 32'(empty), 32'd1);
    check("areset.idx", 32'(alloc_idx), 32'd0);
    check("areset.vld", 32'(alloc_vld), 32'd1);
    m_reset();
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    step("areset.first", 1'b1, 1'b0, 0);
    check("areset.first_busy", 32'(busy), 32'h00000001);

    // Random traffic against the reference.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
           int'($urandom_range(0, W - 1)));
    end
    compare_all("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
